crc32_frame_sequencer: RTL and testbench
========================================

// Module: crc32_frame_sequencer
// PURPOSE
//  Byte-serial CRC-32 controller (reflected poly 0xEDB88320) driving one shared 256x32 lookup table.
//  Accepts a framed 32-bit word stream with valid/ready, issues one table lookup per byte and returns the final CRC per frame.
//  Sits between the packet datapath and the CRC LUT; the result is used for FCS insert and check.
// PARAMETERS
//  LEN_W     16            width of the frame byte counter m_len (saturating)
//  CRC_INIT  32'hFFFFFFFF  CRC register value loaded on s_sop
//  CRC_XOROUT 32'hFFFFFFFF final XOR applied to m_crc
// PORTS
//  clk      in   1      single clock, rising edge
//  rstn     in   1      reset, asynchronous, active-low
//  s_valid  in   1      input word valid
//  s_ready  out  1      block accepts word this cycle
//  s_data   in   32     input word; byte0 = [7:0] is processed first
//  s_sop    in   1      first word of frame
//  s_eop    in   1      last word of frame
//  s_bytes  in   2      valid bytes in the eop word (0 = 4); ignored when s_eop=0
//  m_valid  out  1      result valid; held until m_ready
//  m_ready  in   1      result consumer ready
//  m_crc    out  32     final CRC = crc_reg ^ CRC_XOROUT
//  m_len    out  LEN_W  frame length in bytes, saturates at all-ones
//  busy     out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, crc_reg=CRC_INIT, s_ready=1, m_valid=0, m_crc=0, m_len=0, busy=0.
//  FSM: IDLE -> BYTE on s_valid&s_ready; BYTE -> IDLE after last byte of a non-eop word; BYTE -> DONE after last byte of an eop word;
//   DONE -> IDLE on m_ready.
//  s_ready = (state==IDLE). The word is latched on acceptance; s_sop loads crc_reg=CRC_INIT and len=0 before byte0.
//  BYTE: one byte per cycle: crc_reg <= (crc_reg>>8) ^ T[(crc_reg[7:0]^b)]; cnt counts 0..nb-1, where nb = 4, or s_bytes on an eop word
//   (0 -> 4). Latency: a word of nb bytes holds s_ready low for nb cycles.
//  T is read combinationally; the address is registered from the byte mux, so no extra pipeline stage.
//  DONE: m_valid=1, m_crc and m_len stable until the m_ready handshake; the next frame is accepted the cycle after.
//  m_len += nb per word, clamped at 2^LEN_W-1 (no wrap).
//  s_sop mid-frame: discard the running CRC and restart. Words without a prior sop continue from the current crc_reg.
//  s_sop & s_eop on the same word are legal (1..4 byte frame).
//  m_ready high before m_valid has no effect. rstn low mid-frame aborts silently; no partial result is emitted.
// CONFIGURATION
//  `define CRC_SEQ_CHECK_EN: adds output m_ok (1 bit, reset 0), valid with m_valid; m_ok=1 iff crc_reg (pre-XOROUT)==32'hDEBB20E3,
//   i.e. the frame including its FCS passes the residue check.
//  Without the macro: the m_ok port and its comparator are absent; all other behaviour is identical.
// STRUCTURE
//  Package crc_seq_pkg: state enum {IDLE,BYTE,DONE}, CRC32_POLY_REFL, CRC32_RESIDUE=32'hDEBB20E3, default CRC_INIT/XOROUT.
//  Sub-module: crc32_lut (256x32 combinational table, 8-bit addr -> 32-bit data), one instance.
// TESTING
//  1. Words 0x34333231, 0x38373635, 0x00000039 (sop on w0; eop on w2, s_bytes=1) -> m_crc=0xCBF43926, m_len=9.
//  2. Single word 0x00000000 with sop, eop, s_bytes=1 -> m_crc=0xD202EF8D, m_len=1, and s_ready is low for exactly 1 cycle.
//  3. Case 1 followed by FCS bytes 26 39 F4 CB -> m_ok=1 (CHECK_EN); flip one data bit -> m_ok=0.
//  4. m_ready held low for 10 cycles in DONE -> m_valid, m_crc, m_len stable; s_ready stays 0; a new frame starts after the handshake.
//  5. Re-sop mid-frame after 0xFFFFFFFF, then case 1 -> result identical to case 1.
//     rstn pulse in BYTE -> all outputs at reset values; no m_valid.
//  6. LEN_W=4, 5 full words -> m_len=15 (saturated).

Source files
------------

// File: rtl/crc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_seq_pkg
// Description : Shared types and constants for the CRC-32 frame sequencer:
//               FSM state encoding, reflected polynomial, residue constant,
//               default init/xorout values and a table-entry generator.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BYTE = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [31:0] CRC32_POLY_REFL      = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_INIT_DEFAULT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT_DEFAULT = 32'hFFFFFFFF;

  // One entry of the byte-wise reflected CRC-32 table: eight bit-serial
  // shift/xor steps applied to the index value.
  function automatic logic [31:0] crc32_table_entry(input logic [7:0] idx);
    logic [31:0] v;
    v = {24'h000000, idx};
    for (int k = 0; k < 8; k++) begin
      v = v[0] ? ((v >> 1) ^ CRC32_POLY_REFL) : (v >> 1);
    end
    return v;
  endfunction

endpackage : crc_seq_pkg
`default_nettype wire

// File: rtl/crc32_lut.sv
`default_nettype none
// ============================================================================
// Module      : crc32_lut
// Description : 256 x 32 combinational CRC-32 (reflected) lookup table.
// Ports       : addr [7:0]  - table index
//               data [31:0] - table entry, purely combinational
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_lut
  import crc_seq_pkg::*;
(
  input  logic [7:0]  addr,
  output logic [31:0] data
);

  logic [31:0] w_table [256];

  for (genvar gi = 0; gi < 256; gi++) begin : g_entry
    assign w_table[gi] = crc32_table_entry(8'(gi));
  end

  assign data = w_table[addr];

endmodule : crc32_lut
`default_nettype wire

// File: rtl/crc32_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : crc32_frame_sequencer
// Description : Byte-serial CRC-32 controller. Accepts framed 32-bit words
//               (valid/ready), processes one byte per cycle through a shared
//               256x32 LUT and presents the final CRC and byte length per
//               frame, held until the consumer handshakes.
// Ports       : clk, rstn (async, active-low)
//               s_valid/s_ready/s_data/s_sop/s_eop/s_bytes - word input
//               m_valid/m_ready/m_crc/m_len                - frame result
//               busy                                       - FSM not idle
//               m_ok (only with CRC_SEQ_CHECK_EN)          - residue check
// Config      : `define CRC_SEQ_CHECK_EN adds the m_ok output.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_frame_sequencer
  import crc_seq_pkg::*;
#(
  parameter int unsigned LEN_W      = 16,
  parameter logic [31:0] CRC_INIT   = CRC32_INIT_DEFAULT,
  parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  input  logic             s_sop,
  input  logic             s_eop,
  input  logic [1:0]       s_bytes,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_crc,
  output logic [LEN_W-1:0] m_len,
  output logic             busy
`ifdef CRC_SEQ_CHECK_EN
  ,
  output logic             m_ok
`endif
);

  seq_state_t r_state, w_state_next;

  logic [31:0]      r_crc;
  logic [31:0]      r_word;
  logic [7:0]       r_addr;
  logic [1:0]       r_cnt;
  logic [1:0]       r_last_idx;
  logic             r_eop;
  logic [LEN_W-1:0] r_len;

  logic             w_accept;
  logic [2:0]       w_nb;
  logic [31:0]      w_crc_base;
  logic [LEN_W-1:0] w_len_base;
  logic [LEN_W:0]   w_nb_ext;
  logic [LEN_W:0]   w_len_sum;
  logic [LEN_W-1:0] w_len_next;
  logic [31:0]      w_lut_data;
  logic [31:0]      w_crc_step;
  logic             w_last_byte;
  logic [1:0]       w_byte_sel;
  logic [7:0]       w_next_byte;
  logic [7:0]       w_addr_next;

  crc32_lut u_lut (
    .addr (r_addr),
    .data (w_lut_data)
  );

  assign w_accept   = s_valid & s_ready;
  // s_bytes encodes 4 as 0 and only matters on the last word of a frame.
  assign w_nb       = (s_eop && (s_bytes != 2'd0)) ? {1'b0, s_bytes} : 3'd4;
  assign w_crc_base = s_sop ? CRC_INIT : r_crc;
  assign w_len_base = s_sop ? '0 : r_len;
  assign w_nb_ext   = {{(LEN_W-2){1'b0}}, w_nb};
  assign w_len_sum  = {1'b0, w_len_base} + w_nb_ext;
  // The increment is at most 4, so a carry out means the all-ones clamp.
  assign w_len_next = w_len_sum[LEN_W] ? '1 : w_len_sum[LEN_W-1:0];

  assign w_crc_step  = {8'h00, r_crc[31:8]} ^ w_lut_data;
  assign w_last_byte = (r_cnt == r_last_idx);

  // The LUT address for the following byte is formed from the CRC value
  // being written this cycle, so each byte costs exactly one cycle.
  assign w_byte_sel = r_cnt + 2'd1;
  always_comb begin
    w_next_byte = r_word[7:0];
    case (w_byte_sel)
      2'd0: w_next_byte = r_word[7:0];
      2'd1: w_next_byte = r_word[15:8];
      2'd2: w_next_byte = r_word[23:16];
      2'd3: w_next_byte = r_word[31:24];
      default: w_next_byte = r_word[7:0];
    endcase
  end
  assign w_addr_next = w_crc_step[7:0] ^ w_next_byte;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) begin
          w_state_next = BYTE;
        end
      end
      BYTE: begin
        if (w_last_byte) begin
          w_state_next = r_eop ? DONE : IDLE;
        end
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_crc      <= CRC_INIT;
      r_word     <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_eop      <= 1'b0;
      r_len      <= '0;
    end else if (w_accept) begin
      r_word     <= s_data;
      r_crc      <= w_crc_base;
      r_addr     <= w_crc_base[7:0] ^ s_data[7:0];
      r_cnt      <= '0;
      r_last_idx <= 2'(w_nb - 3'd1);
      r_eop      <= s_eop;
      r_len      <= w_len_next;
    end else if (r_state == BYTE) begin
      r_crc  <= w_crc_step;
      r_cnt  <= r_cnt + 2'd1;
      r_addr <= w_addr_next;
    end
  end

  assign m_crc = r_crc ^ CRC_XOROUT;
  assign m_len = r_len;

`ifdef CRC_SEQ_CHECK_EN
  assign m_ok = m_valid && (r_crc == CRC32_RESIDUE);
`endif

endmodule : crc32_frame_sequencer
`default_nettype wire

// File: tb/tb_crc32_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc32_frame_sequencer
// Description : Self-checking bench for crc32_frame_sequencer. Two instances
//               (LEN_W=16 and LEN_W=4) share one stimulus stream; results are
//               compared against a bit-serial CRC-32 reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc32_frame_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_sop = 1'b0;
  logic        s_eop = 1'b0;
  logic [1:0]  s_bytes = '0;
  logic        m_ready = 1'b0;

  logic        s_ready, m_valid, busy;
  logic [31:0] m_crc;
  logic [15:0] m_len;
  logic        s_ready4, m_valid4, busy4;
  logic [31:0] m_crc4;
  logic [3:0]  m_len4;
`ifdef CRC_SEQ_CHECK_EN
  logic        m_ok, m_ok4;
`endif

  always #5 clk = ~clk;

  crc32_frame_sequencer #(.LEN_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_bytes(s_bytes),
    .m_valid(m_valid), .m_ready(m_ready), .m_crc(m_crc), .m_len(m_len),
    .busy(busy)
`ifdef CRC_SEQ_CHECK_EN
    , .m_ok(m_ok)
`endif
  );

  crc32_frame_sequencer #(.LEN_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .s_sop(s_sop), .s_eop(s_eop), .s_bytes(s_bytes),
    .m_valid(m_valid4), .m_ready(m_ready), .m_crc(m_crc4), .m_len(m_len4),
    .busy(busy4)
`ifdef CRC_SEQ_CHECK_EN
    , .m_ok(m_ok4)
`endif
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] mdl_crc = 32'hFFFFFFFF;
  int          mdl_len = 0;
  logic [31:0] obs_crc;
  int          obs_len;
  int          obs_len4;

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc_byte(input logic [31:0] c,
                                               input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  function automatic int clamp_len(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic sop,
                           input logic eop, input logic [1:0] nbytes);
    int waitc;
    int n;
    waitc = 0;
    @(negedge clk);
    while (!s_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!s_ready) begin
      check_value("s_ready_timeout", 64'(s_ready), 64'd1);
      return;
    end
    s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_bytes = nbytes;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    s_data = $urandom; s_bytes = 2'($urandom);
    if (sop) begin
      mdl_crc = 32'hFFFFFFFF;
      mdl_len = 0;
    end
    n = (eop && nbytes != 2'd0) ? int'(nbytes) : 4;
    for (int i = 0; i < n; i++) mdl_crc = ref_crc_byte(mdl_crc, d[8*i +: 8]);
    mdl_len += n;
  endtask

  task automatic get_result(input string tag, input int hold);
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!m_valid && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check_value({tag, "_valid"}, 64'(m_valid), 64'd1);
    if (!m_valid) return;
    obs_crc = m_crc; obs_len = int'(m_len); obs_len4 = int'(m_len4);
    check_value({tag, "_crc"},    64'(m_crc),    64'(mdl_crc ^ 32'hFFFFFFFF));
    check_value({tag, "_len"},    64'(m_len),    64'(clamp_len(mdl_len, 16)));
    check_value({tag, "_valid4"}, 64'(m_valid4), 64'd1);
    check_value({tag, "_crc4"},   64'(m_crc4),   64'(mdl_crc ^ 32'hFFFFFFFF));
    check_value({tag, "_len4"},   64'(m_len4),   64'(clamp_len(mdl_len, 4)));
`ifdef CRC_SEQ_CHECK_EN
    check_value({tag, "_ok"}, 64'(m_ok), 64'(mdl_crc == 32'hDEBB20E3));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_value({tag, "_hold_valid"}, 64'(m_valid), 64'd1);
      check_value({tag, "_hold_crc"},   64'(m_crc),   64'(mdl_crc ^ 32'hFFFFFFFF));
      check_value({tag, "_hold_len"},   64'(m_len),   64'(clamp_len(mdl_len, 16)));
      check_value({tag, "_hold_ready"}, 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check_value({tag, "_post_valid"}, 64'(m_valid), 64'd0);
    check_value({tag, "_post_ready"}, 64'(s_ready), 64'd1);
  endtask

  task automatic send_check_string(input logic [31:0] w0);
    send_word(w0,           1'b1, 1'b0, 2'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 2'd0);
    send_word(32'h00000039, 1'b0, 1'b1, 2'd1);
  endtask

  initial begin : main
    int lowc;
    int seen;
    int nw;
    logic [1:0] nb;

    // reset state
    repeat (2) @(negedge clk);
    check_value("rst_s_ready", 64'(s_ready), 64'd1);
    check_value("rst_m_valid", 64'(m_valid), 64'd0);
    check_value("rst_m_crc",   64'(m_crc),   64'd0);
    check_value("rst_m_len",   64'(m_len),   64'd0);
    check_value("rst_busy",    64'(busy),    64'd0);
    rstn = 1'b1;

    // case 1: "123456789", with per-word latency on the first word
    send_word(32'h34333231, 1'b1, 1'b0, 2'd0);
    lowc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_ready) break;
      lowc++;
    end
    check_value("word_latency", 64'(lowc), 64'd4);
    send_word(32'h38373635, 1'b0, 1'b0, 2'd0);
    send_word(32'h00000039, 1'b0, 1'b1, 2'd1);
    get_result("case1", 0);
    check_value("case1_const_crc", 64'(obs_crc), 64'h00000000CBF43926);
    check_value("case1_const_len", 64'(obs_len), 64'd9);

    // case 2: single zero byte
    send_word(32'h00000000, 1'b1, 1'b1, 2'd1);
    lowc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) break;
      if (!s_ready) lowc++;
    end
    check_value("case2_busy_cycles", 64'(lowc), 64'd1);
    get_result("case2", 0);
    check_value("case2_const_crc", 64'(obs_crc), 64'h00000000D202EF8D);
    check_value("case2_const_len", 64'(obs_len), 64'd1);

    // case 3: frame plus its FCS hits the residue; one flipped bit does not
    send_word(32'h34333231, 1'b1, 1'b0, 2'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 2'd0);
    send_word(32'hF4392639, 1'b0, 1'b0, 2'd0);
    send_word(32'h000000CB, 1'b0, 1'b1, 2'd1);
    get_result("case3_good", 0);
    check_value("case3_const_crc", 64'(obs_crc), 64'h000000002144DF1C);
    check_value("case3_const_len", 64'(obs_len), 64'd13);
    send_word(32'h34333230, 1'b1, 1'b0, 2'd0);
    send_word(32'h38373635, 1'b0, 1'b0, 2'd0);
    send_word(32'hF4392639, 1'b0, 1'b0, 2'd0);
    send_word(32'h000000CB, 1'b0, 1'b1, 2'd1);
    get_result("case3_bad", 0);
    check_value("case3_bad_not_residue",
                64'(obs_crc == 32'h2144DF1C), 64'd0);

    // case 4: consumer stalls 10 cycles in DONE, then a new frame follows
    send_check_string(32'h34333231);
    get_result("case4_stall", 10);
    send_word(32'h00000000, 1'b1, 1'b1, 2'd1);
    get_result("case4_next", 0);
    check_value("case4_next_crc", 64'(obs_crc), 64'h00000000D202EF8D);

    // case 5: restart mid-frame, then reset pulse while in BYTE
    send_word(32'hFFFFFFFF, 1'b1, 1'b0, 2'd0);
    send_check_string(32'h34333231);
    get_result("case5_resop", 0);
    check_value("case5_const_crc", 64'(obs_crc), 64'h00000000CBF43926);

    send_word(32'h11223344, 1'b1, 1'b0, 2'd0);
    check_value("case5_in_byte", 64'(busy), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check_value("arst_s_ready", 64'(s_ready), 64'd1);
    check_value("arst_m_valid", 64'(m_valid), 64'd0);
    check_value("arst_m_crc",   64'(m_crc),   64'd0);
    check_value("arst_m_len",   64'(m_len),   64'd0);
    check_value("arst_busy",    64'(busy),    64'd0);
    check_value("arst_busy4",   64'(busy4),   64'd0);
    @(negedge clk);
    rstn = 1'b1;
    mdl_crc = 32'hFFFFFFFF;
    mdl_len = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    check_value("arst_no_result", 64'(seen), 64'd0);

    // case 6: five full words saturate the 4-bit length counter
    for (int i = 0; i < 5; i++) begin
      send_word($urandom, (i == 0), (i == 4), 2'd0);
    end
    get_result("case6_sat", 0);
    check_value("case6_len4", 64'(obs_len4), 64'd15);
    check_value("case6_len16", 64'(obs_len), 64'd20);

    // randomized frames: variable lengths, tail sizes, restarts, stalls,
    // and early m_ready that must be ignored
    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        nb = 2'($urandom);
        if (w == nw - 1) m_ready = 1'b0;
        else m_ready = 1'($urandom);
        send_word($urandom, (w == 0) || ($urandom_range(0, 7) == 0),
                  (w == nw - 1), nb);
      end
      get_result("rand", $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_crc32_frame_sequencer
`default_nettype wire
